// File: rtl/inst_rom_pkg.sv
// Shared bus widths, default storage depth and FSM encoding for the
// loadable instruction store.
package inst_rom_pkg;

  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_ROM_AW     = 10;

  typedef logic [INST_BUS_W-1:0]      inst_bus_t;
  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_bus_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } rom_state_e;

  // Big-endian word assembly: the earliest loader bytes form the top of the word.
  function automatic inst_bus_t pack_be(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/inst_rom_ram.sv
// 2^AW x 32 storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module inst_ram_1w1r
  import inst_rom_pkg::*;
#(
  parameter int AW = INST_ROM_AW
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  inst_bus_t       wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output inst_bus_t       rdata_o
);

  inst_bus_t mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom.sv
// Instruction store filled by a byte-serial loader, then served to the fetch
// stage through a combinational read. Fetches return NOP until a load completes.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int AW = INST_ROM_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  inst_addr_bus_t      addr_i,
  output inst_bus_t           inst_o,
  input  logic                ld_start_i,
  input  logic [AW:0]         ld_count_i,
  input  logic                ld_valid_i,
  input  logic [7:0]          ld_byte_i,
  output logic                ld_ready_o,
  output logic                ld_done_o,
  output logic                prog_ok_o
);

  // Loader handshake: a byte transfers on every rising edge where
  // ld_valid_i && ld_ready_o; ld_ready_o depends only on state, never on ld_valid_i.

  localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

  rom_state_e  state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        done_q, done_d;

  logic        byte_acc;
  logic        word_last;
  logic        ram_we;
  logic [AW:0] ptr_inc;
  logic [AW:0] count_clip;
  inst_bus_t   ram_wdata;
  inst_bus_t   ram_rdata;
  logic        addr_in_range;
  logic        fetch_hit;

  assign byte_acc   = ld_valid_i && ld_ready_o;
  assign word_last  = byte_acc && (byte_cnt_q == 2'd3);
  assign ptr_inc    = ptr_q + 1'b1;
  assign count_clip = (ld_count_i > MAX_WORDS) ? MAX_WORDS : ld_count_i;
  assign ram_wdata  = pack_be(asm_q, ld_byte_i);
  // A reset edge must not commit a half-finished final byte.
  assign ram_we     = word_last && rst;

  inst_ram_1w1r #(
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ptr_q[AW-1:0]),
    .wdata_i (ram_wdata),
    .raddr_i (addr_i[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      count_q    <= '0;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    done_d     = 1'b0;
    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (ld_start_i) begin
          ptr_d      = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          count_d    = count_clip;
          if (count_clip == '0) begin
            state_d = ST_READY;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // ld_start_i is deliberately not looked at here.
        if (byte_acc) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = {asm_q[15:0], ld_byte_i};
          if (word_last) begin
            ptr_d = ptr_inc;
            asm_d = '0;
            if (ptr_inc == count_q) begin
              state_d = ST_READY;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    ld_ready_o    = (state_q == ST_LOAD);
    prog_ok_o     = (state_q == ST_READY);
    ld_done_o     = done_q;
    addr_in_range = ((addr_i >> (AW + 2)) == '0);
    fetch_hit     = ce_i && prog_ok_o && addr_in_range;
    inst_o        = fetch_hit ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_inst_rom.sv
// Randomised bench for inst_rom: a cycle-level reference model predicts
// outputs, a negedge monitor pops and compares them.
module tb_inst_rom;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic [31:0] inst;
    logic        done;
    logic        ready;
    logic        ok;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce_i;
  logic [31:0]   addr_i;
  logic [31:0]   inst_o;
  logic          ld_start_i;
  logic [AW:0]   ld_count_i;
  logic          ld_valid_i;
  logic [7:0]    ld_byte_i;
  logic          ld_ready_o;
  logic          ld_done_o;
  logic          prog_ok_o;

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  logic [7:0]  ld_src[$];

  // Reference model: program image plus load progress.
  logic [31:0] m_mem [WORDS];
  bit          m_loading;
  bit          m_ok;
  bit          m_done;
  int          m_target;
  int          m_words;
  logic [7:0]  m_bytes[$];

  inst_rom #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .addr_i     (addr_i),
    .inst_o     (inst_o),
    .ld_start_i (ld_start_i),
    .ld_count_i (ld_count_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_ready_o (ld_ready_o),
    .ld_done_o  (ld_done_o),
    .prog_ok_o  (prog_ok_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("inst_o",     inst_o,            e.inst);
      chk("ld_done_o",  {31'd0, ld_done_o},  {31'd0, e.done});
      chk("ld_ready_o", {31'd0, ld_ready_o}, {31'd0, e.ready});
      chk("prog_ok_o",  {31'd0, prog_ok_o},  {31'd0, e.ok});
    end
  end

  // One driven cycle: apply inputs, predict outputs, advance the model over the edge.
  task automatic cyc(input logic rst_v, input logic ce_v, input logic [31:0] addr_v,
                     input logic start_v, input logic [AW:0] cnt_v,
                     input logic valid_v, input logic [7:0] byte_v);
    exp_t e;
    int   n;
    rst        = rst_v;
    ce_i       = ce_v;
    addr_i     = addr_v;
    ld_start_i = start_v;
    ld_count_i = cnt_v;
    ld_valid_i = valid_v;
    ld_byte_i  = byte_v;

    e.inst  = (ce_v && m_ok && addr_v < 32'(4 * WORDS)) ? m_mem[addr_v / 4] : 32'h0;
    e.done  = m_done;
    e.ready = m_loading;
    e.ok    = m_ok;
    exp_q.push_back(e);

    if (!rst_v) begin
      m_loading = 0;
      m_ok      = 0;
      m_done    = 0;
      m_bytes.delete();
    end else begin
      m_done = 0;
      if (!m_loading) begin
        if (start_v) begin
          n = (int'(cnt_v) > WORDS) ? WORDS : int'(cnt_v);
          if (n == 0) begin
            m_ok   = 1;
            m_done = 1;
          end else begin
            m_loading = 1;
            m_ok      = 0;
            m_target  = n;
            m_words   = 0;
            m_bytes.delete();
          end
        end
      end else if (valid_v) begin
        m_bytes.push_back(byte_v);
        if (m_bytes.size() == 4) begin
          m_mem[m_words] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_words++;
          m_bytes.delete();
          if (m_words == m_target) begin
            m_loading = 0;
            m_ok      = 1;
            m_done    = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 4 * WORDS - 1));
  endfunction

  task automatic fetch(input logic ce_v, input logic [31:0] addr_v);
    cyc(1'b1, ce_v, addr_v, 1'b0, '0, 1'b0, 8'h00);
  endtask

  // mode: 0 continuous valid, 1 valid toggling, 2 random valid.
  // abort_at >= 0 resets as the byte after abort_at accepted bytes is offered.
  task automatic do_load(input int cnt, input int mode, input int abort_at, input bit mid_start);
    int         sent = 0;
    int         ncyc = 0;
    logic       v;
    logic [7:0] b;
    cyc(1'b1, 1'b1, rnd_addr(), 1'b1, cnt[AW:0], 1'b0, 8'h00);
    while (ld_src.size() > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (ncyc % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      b = v ? ld_src[0] : 8'($urandom);
      if (v && sent == abort_at) begin
        cyc(1'b0, 1'b1, rnd_addr(), 1'b0, '0, 1'b1, b);
        ld_src.delete();
      end else begin
        cyc(1'b1, 1'b1, rnd_addr(), (mid_start && ncyc == 6), '0, v, b);
        if (v) begin
          void'(ld_src.pop_front());
          sent++;
        end
      end
      ncyc++;
    end
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);
  endtask

  task automatic push_prog2();
    logic [7:0] p [8];
    p = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h0A};
    foreach (p[i]) ld_src.push_back(p[i]);
  endtask

  initial begin
    rst        = 1'b0;
    ce_i       = 1'b0;
    addr_i     = '0;
    ld_start_i = 1'b0;
    ld_count_i = '0;
    ld_valid_i = 1'b0;
    ld_byte_i  = '0;
    m_loading  = 0;
    m_ok       = 0;
    m_done     = 0;
    repeat (2) @(posedge clk);
    #1;

    // Empty store serves NOPs.
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);

    // Two-word program, continuous then toggling valid.
    push_prog2();
    do_load(2, 0, -1, 1'b0);
    for (int a = 0; a < 8; a++) fetch(1'b1, 32'(a));
    fetch(1'b0, 32'h0);
    fetch(1'b1, 32'h1000);
    push_prog2();
    do_load(2, 1, -1, 1'b0);
    for (int a = 0; a < 8; a++) fetch(1'b1, 32'(a));

    // Oversized count clips to full depth; stray start mid-load.
    for (int i = 0; i < 4 * WORDS; i++) ld_src.push_back(8'($urandom));
    do_load(2047, 2, -1, 1'b1);
    fetch(1'b1, 32'h0000_0FFE);
    fetch(1'b1, 32'h0000_1000);
    fetch(1'b1, 32'hFFFF_FFFC);
    fetch(1'b0, 32'h0000_0010);
    for (int i = 0; i < 40; i++) fetch(1'($urandom_range(0, 3) != 0), rnd_addr());
    for (int i = 0; i < 10; i++) fetch(1'b1, $urandom);

    // Zero-length load from READY.
    cyc(1'b1, 1'b1, 32'h8, 1'b1, '0, 1'b1, 8'hAA);
    fetch(1'b1, 32'h8);
    fetch(1'b1, 32'hC);

    // Reset after five bytes, then a one-word reload.
    for (int i = 0; i < 8; i++) ld_src.push_back(8'($urandom));
    do_load(2, 0, 5, 1'b0);
    fetch(1'b1, 32'h0);
    for (int i = 0; i < 4; i++) ld_src.push_back(8'($urandom));
    do_load(1, 2, -1, 1'b0);
    for (int i = 0; i < 20; i++) fetch(1'b1, rnd_addr());

    fetch(1'b0, 32'h0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter AW, default 10: word-address width, giving 2^AW words of instruction storage.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ce_i  input  1  fetch enable from the core's PC stage.
REQ-005 SHALL have port addr_i  input  32  fetch byte address from the core.
REQ-006 SHALL have port inst_o  output  32  fetched instruction word to the IF/ID stage.
REQ-007 SHALL have port ld_start_i  input  1  single-cycle request to begin a program load.
REQ-008 SHALL have port ld_count_i  input  AW+1  number of words to load, sampled with ld_start_i.
REQ-009 SHALL have port ld_valid_i  input  1  loader byte valid.
REQ-010 SHALL have port ld_byte_i  input  8  loader byte data.
REQ-011 SHALL have port ld_ready_o  output  1  block accepts a loader byte.
REQ-012 SHALL have port ld_done_o  output  1  one-cycle pulse marking load completion.
REQ-013 SHALL have port prog_ok_o  output  1  a complete program is resident and fetches are served.

Function
REQ-014 SHALL implement states EMPTY, LOAD, READY.
REQ-015 Transitions SHALL be: EMPTY/READY + ld_start_i -> LOAD; LOAD + last word written -> READY. ld_start_i while in LOAD SHALL be ignored.
REQ-016 ld_count_i SHALL be clipped to 2^AW. A count of 0 SHALL go directly to READY, with ld_done_o pulsed in the cycle after ld_start_i.
REQ-017 On entry to LOAD, the word pointer and byte counter SHALL clear to 0.
REQ-018 ld_ready_o SHALL be 1 only in LOAD; a byte is accepted on any edge where ld_valid_i && ld_ready_o.
REQ-019 Bytes SHALL be assembled big-endian: the first accepted byte goes to [31:24] and the fourth to [7:0].
REQ-020 On the fourth byte, the assembled word SHALL be written to mem[word_ptr] on that same edge, and word_ptr SHALL increment.
REQ-021 When word_ptr reaches the count, the block SHALL enter READY, pulse ld_done_o for exactly one cycle, and drop ld_ready_o in that same cycle.
REQ-022 inst_o SHALL be a combinational read so the core sees data in the same cycle as addr_i.
REQ-023 inst_o SHALL equal mem[addr_i[AW+1:2]] when ce_i=1, state=READY and addr_i[31:AW+2]=0; otherwise inst_o SHALL be 32'h0 (NOP).
REQ-024 addr_i[1:0] SHALL be ignored.
REQ-025 Fetches during EMPTY or LOAD SHALL return 0, so the core executes NOPs.
REQ-026 Re-entering LOAD from READY SHALL drop prog_ok_o in the first LOAD cycle.
REQ-027 prog_ok_o SHALL be 1 only in READY.

Reset
REQ-028 On rst=0 at a clock edge the block SHALL apply: state=EMPTY, word_ptr=0, byte counter=0, assembly register=0, ld_ready_o=0, ld_done_o=0, prog_ok_o=0, inst_o=0.
REQ-029 The storage array SHALL NOT be reset; contents are retained but unreachable until the next completed load.
REQ-030 A reset in the middle of a load SHALL abandon the partial word, with no write on that edge.

Structure
REQ-031 InstBus/InstAddrBus widths, AW default, and the state encodings SHALL live in the shared define file.
REQ-032 Storage SHALL be one sub-module, inst_ram_1w1r: 2^AW x 32, one synchronous write port, one asynchronous read port.

Verification
REQ-033 Load 2 words, bytes 34,01,00,05,34,02,00,0A → 8 accepted beats, then:
- ld_done_o pulses once.
- mem[0]=34010005 and mem[1]=3402000A.
- addr_i=0 gives inst_o=34010005; addr_i=4 gives 3402000A.
REQ-034 ld_valid_i toggled 1/0 every cycle during the same load → identical memory contents, with done occurring 8 valid beats later.
REQ-035 After reset, before any load: ce_i=1, addr_i=0 → inst_o=0 and prog_ok_o=0; ce_i=0 in READY → inst_o=0.
REQ-036 With AW=10: addr_i=32'h0000_1000 → inst_o=0; addr_i=32'h0000_0FFE → returns mem[1023].
REQ-037 rst=0 after 5 bytes of a 2-word load → mem[0] written, mem[1] not written, state EMPTY; a following 1-word reload then reaches READY.
REQ-038 ld_start_i with ld_count_i=0 → ld_done_o pulses one cycle later, no byte is accepted, prog_ok_o=1; ld_start_i asserted mid-load → ignored, word_ptr undisturbed.
